mul_issue_ctrl: RTL and testbench
=================================

Name: mul_issue_ctrl

Overview:
- Issue/writeback control for the RV32M multiply path; sits directly upstream and downstream of the 33x33 pipelined signed multiplier wrapper.
- Sign/zero-extends 32-bit rs1/rs2 to 33 bits per opcode and drives the multiplier with TC tied to 1.
- Tracks in-flight ops through a valid/op/tag shadow pipeline matched to the multiplier latency.
- Selects the low or high word of the 66-bit product and buffers results in an in-order output FIFO with ready/valid backpressure and credit-based issue throttling.

Parameters:
- MULT_LAT, 2, multiplier latency in clocks from operand sample to PRODUCT valid (3-stage DW = 2).
- OUT_DEPTH, 4, output FIFO entries; must be >= MULT_LAT+2 for full throughput.
- TAG_W, 5, width of the destination/ROB tag carried alongside each op.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  issue request valid.
- req_ready  out  1  block can accept an op.
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req_rs1  in  32  operand A.
- req_rs2  in  32  operand B.
- req_tag  in  TAG_W  destination tag.
- flush  in  1  kill all in-flight and buffered ops.
- mult_a  out  33  extended operand A to multiplier.
- mult_b  out  33  extended operand B to multiplier.
- mult_tc  out  1  constant 1.
- mult_product  in  66  multiplier product.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_data  out  32  selected result word.
- resp_tag  out  TAG_W  tag of result.

Behaviour:
- Reset (async, rst_n=0): shadow pipeline valids=0, FIFO empty, credit count=0, resp_valid=0, resp_data=0, resp_tag=0. req_ready=0 only while rst_n=0.
- fire = req_valid & req_ready & ~flush.
- req_ready = (credit_cnt < OUT_DEPTH). It is derived from registered state only; no combinational path from resp_ready or req_valid.
- Extension:
  - mult_a[32] = rs1[31] unless op=MULHU (then 0).
  - mult_b[32] = rs2[31] for MUL/MULH, 0 for MULHSU/MULHU.
  - mult_a and mult_b are driven to 0 when not fire.
- Shadow pipe: MULT_LAT stages of {valid, op, tag}; stage0 loads {fire, req_op, req_tag}.
- At the last stage, if valid, push to the FIFO: data = op==MUL ? product[31:0] : product[63:32], plus the tag.
- Latency: fire in cycle 0 -> resp_valid in cycle MULT_LAT+1 (3 at default). Sustained throughput is 1 op/clk when resp_ready=1.
- credit_cnt = in-flight + FIFO occupancy. +1 on fire, -1 on pop (resp_valid & resp_ready); both in the same cycle leaves it unchanged. It never exceeds OUT_DEPTH, so the FIFO cannot overflow; a push with the FIFO full is an assertion error.
- FIFO is in-order. resp_data/resp_tag come from the registered head and are stable while resp_valid & ~resp_ready. An empty FIFO with a simultaneous push does not bypass; the data appears next cycle.
- Pointers wrap modulo OUT_DEPTH. The full/empty decision uses an occupancy counter.
- flush (synchronous): all shadow valids, FIFO contents and credit_cnt are cleared next edge; resp_valid=0 the next cycle. A req or pop in the flush cycle is discarded (no fire, pop ignored). Products already in the multiplier are dropped because their shadow valid is cleared.
- Reset mid-operation: everything is discarded; same as the reset values.

Optional Feature:
- Macro: MUL_PERF_CNT_EN.
- Defined: adds output ports perf_ops[31:0] (count of fires) and perf_stall[31:0] (cycles with req_valid & ~req_ready).
  - Both counters wrap at 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: no counters and no ports; all other behaviour is identical.

Decomposition:
- Shared package mul_pkg:
  - typedef enum mul_op_e {MUL, MULH, MULHSU, MULHU}.
  - localparam MUL_DEFAULT_LAT=2.
  - struct mul_meta_t {valid, op, tag}.
- One sub-module: mul_resp_fifo, a generic sync FIFO with occupancy counter and flush.

Test Plan:
- MUL rs1=0xFFFFFFFF, rs2=0x00000002 -> resp_data=0xFFFFFFFE 3 cycles after fire; tag echoed.
- MULH/MULHSU/MULHU, rs1=0x80000000, rs2=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0x80000000.
  - MULHU -> 0x7FFFFFFF.
- Back-to-back 10 ops with resp_ready=1 -> req_ready never drops; 10 in-order responses on consecutive cycles.
- resp_ready=0 with continuous req_valid -> exactly 4 fires, then req_ready=0. Raising resp_ready drains 4 results in order and issue resumes.
- flush with 2 in flight and 1 buffered -> resp_valid=0 next cycle, credit_cnt=0, no stale result ever appears.
- rst_n low for 1 cycle mid-stream -> all outputs at reset values asynchronously; first new op returns correctly after 3 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the RV32M multiply issue path
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    localparam int MUL_DEFAULT_LAT = 2;
    // Tags up to this width ride the shadow pipe; wider TAG_W values are truncated.
    localparam int MUL_MAX_TAG_W   = 16;

    typedef struct packed {
        logic                     valid;
        mul_op_e                  op;
        logic [MUL_MAX_TAG_W-1:0] tag;
    } mul_meta_t;

    function automatic logic [32:0] mul_ext(input logic [31:0] v, input logic sgn);
        return {sgn & v[31], v};
    endfunction

endpackage

// File: rtl/mul_resp_fifo.sv
// rtl/mul_resp_fifo.sv - in-order sync FIFO with occupancy counter, flush and registered head
module mul_resp_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid & ~full;
    assign pop      = m_tvalid & m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue credits guarantee room; a push into a full FIFO means the credit math broke.
    assert property (@(posedge clk) disable iff (!rst_n) !(s_tvalid && full && !flush));

endmodule

// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - RV32M multiply issue/writeback control; MUL_PERF_CNT_EN adds perf counters
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int MULT_LAT  = MUL_DEFAULT_LAT,
    parameter int OUT_DEPTH = 4,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [32:0]      mult_a,
    output logic [32:0]      mult_b,
    output logic             mult_tc,
    input  logic [65:0]      mult_product,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int ENT_W = 32 + TAG_W;

    mul_op_e                  op;
    logic                     fire;
    logic                     pop;
    logic                     push;
    logic [CNT_W-1:0]         credit_cnt;
    mul_meta_t                pipe [MULT_LAT];
    mul_meta_t                last;
    logic [ENT_W-1:0]         push_data;
    logic [ENT_W-1:0]         head_data;
    logic [MUL_MAX_TAG_W+1:0] unused_meta;

    assign op        = mul_op_e'(req_op);
    assign req_ready = rst_n & (credit_cnt < CNT_W'(OUT_DEPTH));
    assign fire      = req_valid & req_ready & ~flush;
    assign pop       = resp_valid & resp_ready & ~flush;
    assign mult_tc   = 1'b1;

    always_comb begin
        mult_a = '0;
        mult_b = '0;
        if (fire) begin
            mult_a = mul_ext(req_rs1, op != MULHU);
            mult_b = mul_ext(req_rs2, (op == MUL) || (op == MULH));
        end
    end

    // Shadow pipe mirrors the multiplier so the op/tag line up with its product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= fire;
            pipe[0].op    <= op;
            pipe[0].tag   <= MUL_MAX_TAG_W'(req_tag);
            for (int i = 1; i < MULT_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (flush) begin
                for (int i = 0; i < MULT_LAT; i++) begin
                    pipe[i].valid <= 1'b0;
                end
            end
        end
    end

    assign last        = pipe[MULT_LAT-1];
    assign push        = last.valid & ~flush;
    assign push_data   = {(last.op == MUL) ? mult_product[31:0] : mult_product[63:32],
                          last.tag[TAG_W-1:0]};
    assign unused_meta = {mult_product[65:64], last.tag};

    // Credits cover in-flight plus buffered ops, so the FIFO can never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= '0;
        end else if (flush) begin
            credit_cnt <= '0;
        end else if (fire && !pop) begin
            credit_cnt <= credit_cnt + CNT_W'(1);
        end else if (pop && !fire) begin
            credit_cnt <= credit_cnt - CNT_W'(1);
        end
    end

    mul_resp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OUT_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .s_tvalid (push),
        .s_tdata  (push_data),
        .m_tvalid (resp_valid),
        .m_tready (resp_ready),
        .m_tdata  (head_data)
    );

    assign resp_data = head_data[ENT_W-1:TAG_W];
    assign resp_tag  = head_data[TAG_W-1:0];

`ifdef MUL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (fire) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (req_valid && !req_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - randomized scoreboard bench for mul_issue_ctrl
module tb_mul_issue_ctrl;

    localparam int TAG_W = 5;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic [32:0]      mult_a;
    logic [32:0]      mult_b;
    logic             mult_tc;
    logic [65:0]      mult_product;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
`ifdef MUL_PERF_CNT_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_stall;
`endif

    mul_issue_ctrl #(.MULT_LAT(2), .OUT_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_tag      (req_tag),
        .flush        (flush),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_tc      (mult_tc),
        .mult_product (mult_product),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_tag     (resp_tag)
`ifdef MUL_PERF_CNT_EN
        ,
        .perf_ops     (perf_ops),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Two-stage signed 33x33 multiplier standing in for the DW wrapper.
    logic signed [65:0] p1 = '0;
    logic signed [65:0] p2 = '0;
    always @(posedge clk) begin
        p1 <= $signed(mult_a) * $signed(mult_b);
        p2 <= p1;
    end
    assign mult_product = p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    logic [31:0]      seen_data[$];
    logic [TAG_W-1:0] seen_tag[$];
    int               seen_cyc[$];
    int               n_chk  = 0;
    int               n_pass = 0;
    int               fires  = 0;
    int               stalls = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // RV32M semantics straight from 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sbv = longint'($signed(b));
        longint     ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            2'd0, 2'd1: p = sa * sbv;
            2'd2:       p = sa * ub;
            default:    p = {32'b0, a} * {32'b0, b};
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    always @(negedge clk) begin
        logic fire_now;
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            fires  = 0;
            stalls = 0;
        end else begin
            check("req_ready_vs_credit", req_ready, sb.size() < DEPTH);
            fire_now = req_valid & req_ready & ~flush;
            if (!fire_now) check("mult_idle_zero", {mult_a, mult_b}, 0);
            if (req_valid && !req_ready) stalls++;
            if (flush) begin
                sb.delete();
            end else begin
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_data", resp_data, e.data);
                        check("resp_tag", resp_tag, e.tag);
                    end
                    seen_data.push_back(resp_data);
                    seen_tag.push_back(resp_tag);
                    seen_cyc.push_back(cyc);
                end
                if (fire_now) begin
                    sb.push_back('{model(req_op, req_rs1, req_rs2), req_tag});
                    fires++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
        req_valid = v;
        req_op    = op;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = t;
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(3))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(3));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand(input logic v);
        drive(v, 2'($urandom_range(3)), rnd_opnd(), rnd_opnd(), TAG_W'($urandom));
    endtask

    task automatic wait_resp(input int target, input string name);
        for (int i = 0; i < 60 && seen_data.size() < target; i++) step();
        check(name, seen_data.size() >= target, 1);
    endtask

    task automatic single_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [TAG_W-1:0] t, input string name);
        int fc;
        int base;
        base = seen_data.size();
        check({name, "_ready"}, req_ready, 1);
        drive(1'b1, op, a, b, t);
        fc = cyc;
        step();
        req_valid = 1'b0;
        wait_resp(base + 1, {name, "_timeout"});
        if (seen_cyc.size() > base) check({name, "_latency"}, seen_cyc[base] - fc, 3);
    endtask

    initial begin
        int base;
        int f0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 32'd0, '0);
        #3;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_tag", resp_tag, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed MUL with latency and tag echo.
        base = seen_data.size();
        single_latency(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, "mul");
        if (seen_data.size() > base) begin
            check("mul_value", seen_data[base], 32'hFFFF_FFFE);
            check("mul_tag", seen_tag[base], 5'd5);
        end

        // High-word variants back to back.
        base = seen_data.size();
        drive(1'b1, 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1); step();
        drive(1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2); step();
        drive(1'b1, 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3); step();
        req_valid = 1'b0;
        wait_resp(base + 3, "mulh_timeout");
        if (seen_data.size() >= base + 3) begin
            check("mulh_value", seen_data[base], 32'h0000_0000);
            check("mulhsu_value", seen_data[base+1], 32'h8000_0000);
            check("mulhu_value", seen_data[base+2], 32'h7FFF_FFFF);
        end

        // Ten back-to-back ops at full throughput.
        base = seen_data.size();
        for (int i = 0; i < 10; i++) begin
            check("b2b_ready", req_ready, 1);
            drive(1'b1, 2'($urandom_range(3)), rnd_opnd(), rnd_opnd(), TAG_W'(i));
            step();
        end
        req_valid = 1'b0;
        wait_resp(base + 10, "b2b_timeout");
        if (seen_data.size() >= base + 10)
            for (int i = 1; i < 10; i++) check("b2b_consecutive", seen_cyc[base+i] - seen_cyc[base+i-1], 1);

        // Backpressure: credits stop issue after OUT_DEPTH fires.
        resp_ready = 1'b0;
        f0 = fires;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            step();
        end
        req_valid = 1'b0;
        check("bp_fire_count", fires - f0, 4);
        check("bp_ready_low", req_ready, 0);
        base = seen_data.size();
        resp_ready = 1'b1;
        wait_resp(base + 4, "bp_drain_timeout");
        step();
        single_latency(2'd2, rnd_opnd(), rnd_opnd(), 5'd9, "bp_resume");

        // Flush with one buffered and two in flight.
        resp_ready = 1'b0;
        drive_rand(1'b1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !resp_valid; i++) step();
        check("flush_setup_buffered", resp_valid, 1);
        drive_rand(1'b1); step();
        drive_rand(1'b1); step();
        drive_rand(1'b1);
        flush      = 1'b1;
        resp_ready = 1'b1;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_resp_valid", resp_valid, 0);
        check("flush_req_ready", req_ready, 1);
        base = seen_data.size();
        for (int i = 0; i < 8; i++) step();
        check("flush_no_stale", seen_data.size(), base);
        resp_ready = 1'b0;
        f0 = fires;
        for (int i = 0; i < 8; i++) begin
            drive_rand(1'b1);
            step();
        end
        req_valid = 1'b0;
        check("flush_credit_zero", fires - f0, 4);
        resp_ready = 1'b1;
        wait_resp(base + 4, "flush_drain_timeout");

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1);
            step();
        end
        resp_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 0);
        check("arst_resp_data", resp_data, 0);
        check("arst_resp_tag", resp_tag, 0);
        check("arst_req_ready", req_ready, 0);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        single_latency(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd17, "post_rst");

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive_rand($urandom_range(3) != 0);
            resp_ready = ($urandom_range(3) != 0);
            flush      = ($urandom_range(49) == 0);
            step();
        end
        req_valid  = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("final_drained", sb.size(), 0);
        check("final_idle", resp_valid, 0);
`ifdef MUL_PERF_CNT_EN
        check("perf_ops", perf_ops, 32'(fires));
        check("perf_stall", perf_stall, 32'(stalls));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
